sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25: SDRAM byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles without sd_ack before abort; range 1..1023.
REQ-003 SHALL have port clk_sys  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port rq_req  in  3  per-requester level request; index 0=download, 1=C64 bus, 2=REU.
REQ-006 SHALL have port rq_we  in  3  per-requester write enable, 1=write.
REQ-007 SHALL have port rq_addr  in  3*ADDR_W  packed addresses; slice i belongs to requester i.
REQ-008 SHALL have port rq_wdata  in  24  packed write bytes; slice i belongs to requester i.
REQ-009 SHALL have port rq_ack  out  3  one-cycle completion pulse per requester.
REQ-010 SHALL have port rq_rdata  out  8  read byte from the last completed read, shared by all requesters.
REQ-011 SHALL have port sd_req  out  1  request to SDRAM controller.
REQ-012 SHALL have port sd_we  out  1  write enable to controller.
REQ-013 SHALL have port sd_addr  out  ADDR_W  address to controller.
REQ-014 SHALL have port sd_wdata  out  8  write byte to controller.
REQ-015 SHALL have port sd_rdata  in  8  read byte from controller.
REQ-016 SHALL have port sd_ack  in  1  controller completion pulse.
REQ-017 SHALL have port timeout_err  out  1  sticky flag: a transaction timed out.

Function
REQ-018 SHALL implement the states IDLE, BUSY and ACK.
- IDLE->BUSY: any rq_req is high.
- BUSY->ACK: sd_ack is high, or the timeout expires.
- ACK->IDLE: unconditionally.
REQ-019 SHALL grant requester 0 with fixed highest priority.
REQ-020 SHALL arbitrate requesters 1 and 2 round-robin: a last-granted pointer prefers the requester not served most recently; the pointer is updated only on a grant to 1 or 2.
REQ-021 SHALL, on the IDLE->BUSY edge, latch the grant index, rq_we, rq_addr and rq_wdata of the granted requester into sd_we, sd_addr and sd_wdata.
REQ-022 SHALL hold sd_req high throughout BUSY and low in all other states.
REQ-023 SHALL hold the latched values stable while in BUSY.
REQ-024 SHALL, on sd_ack in BUSY, capture sd_rdata into rq_rdata if the transaction is a read; rq_rdata is unchanged on writes.
REQ-025 SHALL pulse rq_ack[grant] for exactly the one ACK cycle.
REQ-026 SHALL meet this minimum latency: req sampled in cycle 0, sd_req high in cycle 1, sd_ack in cycle 1, rq_ack in cycle 2, next grant in cycle 3 at the earliest.
REQ-027 SHALL count BUSY cycles with a 10-bit counter cleared on BUSY entry.
REQ-028 SHALL, when the counter reaches TIMEOUT with no sd_ack, enter ACK with rq_rdata=8'hFF (reads only) and set timeout_err.
REQ-029 SHALL accept sd_ack on the same cycle the counter reaches TIMEOUT as a normal completion, with no error.
REQ-030 SHALL ignore sd_ack in IDLE and ACK.
REQ-031 SHALL complete a granted transaction normally and still pulse its ack if the granted requester drops rq_req mid-transaction.
REQ-032 SHALL ignore rq_req of non-granted requesters until the next IDLE cycle.
REQ-033 SHALL not re-arbitrate in the ACK cycle.

Reset
REQ-034 SHALL, while reset_n is low at a clock edge, force the state to IDLE, and sd_req, sd_we, rq_ack, timeout_err, the counter and the round-robin pointer (prefer 1) to 0, with sd_addr, sd_wdata and rq_rdata at 0.
REQ-035 SHALL, on reset asserted mid-BUSY, abandon the transaction with no rq_ack pulse.

Configuration
REQ-036 SHALL, when the macro SDRAM_ARB_REU_PORT_EN is defined, arbitrate all three requesters as specified.
REQ-037 SHALL, when SDRAM_ARB_REU_PORT_EN is undefined, treat rq_req[2] as 0, tie rq_ack[2] to 0 and remove the round-robin pointer, so requester 1 always has second priority.

Structure
REQ-038 SHALL place the state enum, the requester index constants (RQ_DL, RQ_C64, RQ_REU) and the timeout-counter width in shared package sdram_arb_pkg.
REQ-039 SHALL place the round-robin choice for requesters 1 and 2 in sub-module sdram_arb_rr_pick: combinational pick plus the registered pointer.

Verification
REQ-040 SHALL cover this scenario: C64 read of addr 0x0001234 with the controller returning 0x5A after 3 cycles -> sd_addr=0x0001234, sd_req high 3 cycles, rq_ack[1] one pulse, rq_rdata=0x5A.
REQ-041 SHALL cover this scenario: rq_req 1 and 2 held continuously, controller acks in 1 cycle -> grants alternate 1,2,1,2, each ack 3 cycles apart.
REQ-042 SHALL cover this scenario: download requester 0 asserted together with 1 and 2 -> 0 is granted first; then 1 and 2 per the pointer.
REQ-043 SHALL cover this scenario: TIMEOUT=4 and sd_ack never arrives on a read -> sd_req high exactly 4 cycles, rq_rdata=0xFF, timeout_err stays 1 until reset.
REQ-044 SHALL cover this scenario: reset_n low in the 2nd BUSY cycle -> next cycle IDLE, sd_req=0, no rq_ack pulse.
REQ-045 SHALL cover this scenario: build without SDRAM_ARB_REU_PORT_EN and assert rq_req[2] alone for 20 cycles -> no sd_req, rq_ack stays 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared state encoding, requester indices and timeout-counter width for the SDRAM arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    localparam int NUM_RQ = 3;

    typedef logic [1:0] rq_idx_t;

    localparam rq_idx_t RQ_DL  = 2'd0;
    localparam rq_idx_t RQ_C64 = 2'd1;
    localparam rq_idx_t RQ_REU = 2'd2;

    localparam int TMO_CNT_W = 10;

    typedef logic [TMO_CNT_W-1:0] tmo_cnt_t;

    // One-hot of a requester index; unused encodings map to no requester.
    function automatic logic [NUM_RQ-1:0] rq_onehot(input rq_idx_t idx);
        logic [NUM_RQ-1:0] oh;
        case (idx)
            RQ_DL:   oh = 3'b001;
            RQ_C64:  oh = 3'b010;
            RQ_REU:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Requester-side and controller-side bus of the SDRAM arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold rq_req until rq_ack; the controller ends a command with sd_ack.
interface sdram_arb_if #(
    parameter int ADDR_W = 25
);
    import sdram_arb_pkg::*;

    // Requester side: packed per-requester slices, slice i belongs to requester i.
    logic [NUM_RQ-1:0]        rq_req;
    logic [NUM_RQ-1:0]        rq_we;
    logic [NUM_RQ*ADDR_W-1:0] rq_addr;
    logic [NUM_RQ*8-1:0]      rq_wdata;
    logic [NUM_RQ-1:0]        rq_ack;
    logic [7:0]               rq_rdata;

    // Controller side.
    logic                     sd_req;
    logic                     sd_we;
    logic [ADDR_W-1:0]        sd_addr;
    logic [7:0]               sd_wdata;
    logic [7:0]               sd_rdata;
    logic                     sd_ack;

    logic                     timeout_err;

    // Arbiter view.
    modport master (
        input  rq_req, rq_we, rq_addr, rq_wdata, sd_rdata, sd_ack,
        output rq_ack, rq_rdata, sd_req, sd_we, sd_addr, sd_wdata, timeout_err
    );

    // Requesters and controller view.
    modport slave (
        output rq_req, rq_we, rq_addr, rq_wdata, sd_rdata, sd_ack,
        input  rq_ack, rq_rdata, sd_req, sd_we, sd_addr, sd_wdata, timeout_err
    );

endinterface

// File: rtl/sdram_arb_rr_pick.sv
// Chooses between the C64 and REU requesters; round-robin when SDRAM_ARB_REU_PORT_EN is defined.
// Latency: pick is combinational; the preference pointer updates on the grant edge.
// Backpressure: none; the pointer only moves when the top actually grants C64 or REU.
module sdram_arb_rr_pick (
`ifdef SDRAM_ARB_REU_PORT_EN
    input  logic clk_sys,
    input  logic reset_n,
    input  logic take,
`endif
    input  logic req_c64,
    input  logic req_reu,
    output logic pick_reu
);

`ifdef SDRAM_ARB_REU_PORT_EN
    // prefer_reu_q = 1 means C64 was served most recently, so REU wins a tie.
    logic prefer_reu_q;
    logic prefer_reu_d;

    // Flip the preference away from whichever requester gets this grant.
    always_comb begin
        prefer_reu_d = prefer_reu_q;
        if (take) begin
            prefer_reu_d = !pick_reu;
        end
    end

    // Preference register; reset favours C64.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            prefer_reu_q <= 1'b0;
        end else begin
            prefer_reu_q <= prefer_reu_d;
        end
    end

    assign pick_reu = req_reu && (!req_c64 || prefer_reu_q);
`else
    // Without the REU port C64 always ranks second; REU is masked upstream.
    assign pick_reu = req_reu && !req_c64;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Three-way arbiter in front of a single-byte SDRAM controller (REU port under SDRAM_ARB_REU_PORT_EN).
// Latency: grant on the IDLE edge, sd_req next cycle, rq_ack one cycle after sd_ack; 3 cycles minimum per access.
// Backpressure: one command in flight; other requests wait until IDLE; BUSY aborts after TIMEOUT cycles.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    sdram_arb_if.master bus
);

`ifdef SDRAM_ARB_REU_PORT_EN
    localparam logic [NUM_RQ-1:0] RQ_MASK = 3'b111;
`else
    localparam logic [NUM_RQ-1:0] RQ_MASK = 3'b011;
`endif

    // tmo_cnt_q counts BUSY cycles already spent, so the cycle seeing TMO_LAST is the TIMEOUT-th one.
    localparam tmo_cnt_t TMO_LAST = tmo_cnt_t'(TIMEOUT - 1);

    arb_state_e        state_q,       state_d;
    rq_idx_t           grant_q,       grant_d;
    logic              sd_we_q,       sd_we_d;
    logic [ADDR_W-1:0] sd_addr_q,     sd_addr_d;
    logic [7:0]        sd_wdata_q,    sd_wdata_d;
    logic [7:0]        rq_rdata_q,    rq_rdata_d;
    tmo_cnt_t          tmo_cnt_q,     tmo_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic [NUM_RQ-1:0] req_eff;
    logic              start;
    logic              pick_reu;
    rq_idx_t           grant_sel;

    assign req_eff = bus.rq_req & RQ_MASK;
    assign start   = (state_q == IDLE) && (|req_eff);

`ifdef SDRAM_ARB_REU_PORT_EN
    logic rr_take;
    assign rr_take = start && !req_eff[RQ_DL];
`endif

    sdram_arb_rr_pick u_rr_pick (
`ifdef SDRAM_ARB_REU_PORT_EN
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .take     (rr_take),
`endif
        .req_c64  (req_eff[RQ_C64]),
        .req_reu  (req_eff[RQ_REU]),
        .pick_reu (pick_reu)
    );

    // Download wins outright; otherwise the sub-module decides between C64 and REU.
    always_comb begin
        grant_sel = RQ_C64;
        if (req_eff[RQ_DL]) begin
            grant_sel = RQ_DL;
        end else if (pick_reu) begin
            grant_sel = RQ_REU;
        end
    end

    // Next state, command latch, read-data capture and timeout tracking.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sd_we_d       = sd_we_q;
        sd_addr_d     = sd_addr_q;
        sd_wdata_d    = sd_wdata_q;
        rq_rdata_d    = rq_rdata_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = BUSY;
                    grant_d    = grant_sel;
                    sd_we_d    = bus.rq_we[grant_sel];
                    sd_addr_d  = bus.rq_addr[int'(grant_sel)*ADDR_W +: ADDR_W];
                    sd_wdata_d = bus.rq_wdata[int'(grant_sel)*8 +: 8];
                    tmo_cnt_d  = '0;
                end
            end
            BUSY: begin
                // A real ack on the last allowed cycle still counts as success.
                if (bus.sd_ack) begin
                    state_d = ACK;
                    if (!sd_we_q) begin
                        rq_rdata_d = bus.sd_rdata;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = ACK;
                    timeout_err_d = 1'b1;
                    if (!sd_we_q) begin
                        rq_rdata_d = 8'hFF;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + tmo_cnt_t'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= RQ_DL;
            sd_we_q       <= 1'b0;
            sd_addr_q     <= '0;
            sd_wdata_q    <= '0;
            rq_rdata_q    <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sd_we_q       <= sd_we_d;
            sd_addr_q     <= sd_addr_d;
            sd_wdata_q    <= sd_wdata_d;
            rq_rdata_q    <= rq_rdata_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.sd_req      = (state_q == BUSY);
    assign bus.sd_we       = sd_we_q;
    assign bus.sd_addr     = sd_addr_q;
    assign bus.sd_wdata    = sd_wdata_q;
    assign bus.rq_rdata    = rq_rdata_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.rq_ack      = (state_q == ACK) ? (rq_onehot(grant_q) & RQ_MASK) : '0;

endmodule
